// File: rtl/seq_detect_ctrl.sv
// Frame serialiser with a runtime-programmable Mealy pattern detector (overlap allowed)
// and a per-frame saturating match counter.
module seq_detect_ctrl #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [PAT_MAX-1:0]             cfg_pat,
  input  logic [$clog2(PAT_MAX+1)-1:0]   cfg_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           bit_valid,
  output logic                           bit_out,
  output logic                           det,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int LEN_W  = $clog2(PAT_MAX+1);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_MAX);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'((PAT_MAX < 3) ? PAT_MAX : 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [DATA_W-1:0]    data_q;
  logic [IDX_W-1:0]     idx_q;
  logic [PAT_MAX-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q;
  logic [PAT_MAX-2:0]   hist_q;
  logic [FILL_W-1:0]    fill_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 bit_valid_q;
  logic                 bit_out_q;
  logic                 busy_q;
  logic                 done_q;

  logic [PAT_MAX-1:0]   window;
  logic [PAT_MAX-1:0]   mask;
  logic                 fill_ok;
  logic                 det_d;
  logic [LEN_W-1:0]     len_d;
  logic [PAT_MAX-2:0]   hist_d;
  logic [FILL_W-1:0]    fill_d;
  logic [CNT_W-1:0]     cnt_d;

  always_comb begin
    window = {hist_q, bit_out_q};
    mask   = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // fill >= len-1 written as fill+1 >= len to avoid underflow
    fill_ok = (LEN_W'(fill_q) + LEN_W'(1)) >= len_q;
    det_d   = (state_q == S_SHIFT) && fill_ok && (((window ^ pat_q) & mask) == '0);

    if (cfg_len == '0) begin
      len_d = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_MAX)) begin
      len_d = LEN_W'(PAT_MAX);
    end else begin
      len_d = cfg_len;
    end

    hist_d = window[PAT_MAX-2:0];
    fill_d = (fill_q == FILL_W'(PAT_MAX-1)) ? fill_q : fill_q + FILL_W'(1);
    cnt_d  = (det_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Frame is held as a left-shifting register: bit_out_q always carries data[DATA_W-1-idx].
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      pat_q       <= PAT_MAX'(1);
      len_q       <= RST_LEN;
      hist_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            pat_q  <= cfg_pat;
            len_q  <= len_d;
            hist_q <= '0;
            fill_q <= '0;
          end else if (in_valid) begin
            data_q      <= {in_data[DATA_W-2:0], 1'b0};
            bit_out_q   <= in_data[DATA_W-1];
            idx_q       <= '0;
            cnt_q       <= '0;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          hist_q <= hist_d;
          fill_q <= fill_d;
          cnt_q  <= cnt_d;
          idx_q  <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_W-1)) begin
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            bit_out_q <= data_q[DATA_W-1];
            data_q    <= data_q << 1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !cfg_we;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign det       = det_d;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a full-width instance and a 2-bit-counter
// instance share stimulus; expectations are queued at issue and popped by a monitor.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic [15:0] in_data;

  logic       in_ready, bit_valid, bit_out, det, busy, done;
  logic [7:0] match_cnt;
  logic       s_in_ready, s_bit_valid, s_bit_out, s_det, s_busy, s_done;
  logic [1:0] s_match_cnt;

  seq_detect_ctrl #(.DATA_W(16), .PAT_MAX(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bit_valid(bit_valid), .bit_out(bit_out), .det(det), .busy(busy),
    .done(done), .match_cnt(match_cnt)
  );

  seq_detect_ctrl #(.DATA_W(16), .PAT_MAX(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .bit_valid(s_bit_valid), .bit_out(s_bit_out), .det(s_det), .busy(s_busy),
    .done(s_done), .match_cnt(s_match_cnt)
  );

  typedef struct packed { logic b; logic d; } bit_exp_t;
  typedef struct packed { logic [7:0] c8; logic [1:0] c2; } cnt_exp_t;
  typedef struct packed { logic rdy; logic [7:0] c8; logic [1:0] c2; } idle_exp_t;

  bit_exp_t  bitq[$];
  cnt_exp_t  cntq[$];
  idle_exp_t idleq[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic end_req  = 1'b0;
  logic end_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit_exp_t  eb;
  cnt_exp_t  ec;
  idle_exp_t ei;

  always @(negedge clk) begin
    if (bit_valid) begin
      if (bitq.size() == 0) begin
        check("unexpected_bit", 32'd1, 32'd0);
      end else begin
        eb = bitq.pop_front();
        check("bit_out", bit_out, eb.b);
        check("det", det, eb.d);
        check("sat_bit_out", s_bit_out, eb.b);
        check("sat_det", s_det, eb.d);
      end
    end else if (det) begin
      check("det_outside_shift", det, 32'd0);
    end
    if (done) begin
      if (cntq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        ec = cntq.pop_front();
        check("match_cnt", match_cnt, ec.c8);
        check("sat_match_cnt", s_match_cnt, ec.c2);
        check("sat_done", s_done, 32'd1);
        check("busy_in_done", busy, 32'd1);
      end
    end
    if (idleq.size() != 0) begin
      ei = idleq.pop_front();
      check("idle_in_ready", in_ready, ei.rdy);
      check("idle_sat_in_ready", s_in_ready, ei.rdy);
      check("idle_bit_valid", bit_valid, 32'd0);
      check("idle_busy", busy, 32'd0);
      check("idle_sat_busy", s_busy, 32'd0);
      check("idle_done", done, 32'd0);
      check("idle_det", det, 32'd0);
      check("idle_match_cnt", match_cnt, ei.c8);
      check("idle_sat_match_cnt", s_match_cnt, ei.c2);
    end
    if (end_req && !end_done) begin
      check("bits_left", bitq.size(), 32'd0);
      check("cnts_left", cntq.size(), 32'd0);
      end_done = 1'b1;
    end
  end

  task automatic push_exp(input logic [15:0] d, input logic [15:0] m, input int c, input int n);
    for (int i = 0; i < n; i++) bitq.push_back('{b: d[15-i], d: m[15-i]});
    if (c >= 0) cntq.push_back('{c8: 8'(c), c2: 2'((c > 3) ? 3 : c)});
  endtask

  task automatic wait_accept();
    logic acc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    $display("FAIL handshake_timeout: frame not accepted within 100 cycles");
    $fatal(1, "handshake timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL idle_timeout: block never returned to idle");
    $fatal(1, "idle timeout");
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] m, input int c);
    push_exp(d, m, c, 16);
    in_data  = d;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l);
    wait_idle();
    cfg_pat = p;
    cfg_len = l;
    cfg_we  = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idleq.push_back('{rdy: 1'b1, c8: 8'd0, c2: 2'd0});

    // default 001: matches at bits 3,6,9,12,15
    send(16'h1249, 16'h1249, 5);
    // history spans frames: trailing 00 then leading 1
    send(16'h0000, 16'h0000, 0);
    send(16'h8000, 16'h8000, 1);

    // cfg write during SHIFT is ignored; follow-up frame still sees 001
    send(16'h1249, 16'h1249, 5);
    repeat (3) @(posedge clk);
    #1; cfg_pat = 8'h01; cfg_len = 4'd1; cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    send(16'h8000, 16'h0000, 0);

    // overlap 11, history cleared by the write
    write_cfg(8'h03, 4'd2);
    send(16'hFFFF, 16'h7FFF, 15);

    // len 0 clamps to 1, pattern 1: every bit matches, 2-bit counter saturates
    write_cfg(8'h01, 4'd0);
    send(16'hFFFF, 16'hFFFF, 16);

    // simultaneous cfg_we and in_valid: config first, len 15 clamps to 8
    wait_idle();
    cfg_pat = 8'hFF; cfg_len = 4'd15; cfg_we = 1'b1;
    in_data = 16'hFFFF; in_valid = 1'b1;
    push_exp(16'hFFFF, 16'h01FF, 9, 16);
    idleq.push_back('{rdy: 1'b0, c8: 8'd16, c2: 2'd3});
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_accept();

    // reset during bit 5: six bits seen, no done, state back to defaults
    wait_idle();
    push_exp(16'h1249, 16'h0000, -1, 6);
    in_data = 16'h1249; in_valid = 1'b1;
    wait_accept();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idleq.push_back('{rdy: 1'b1, c8: 8'd0, c2: 2'd0});
    send(16'h1249, 16'h1249, 5);

    for (int i = 0; i < 200; i++) begin
      if (bitq.size() == 0 && cntq.size() == 0 && idleq.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (end_done) break;
      @(posedge clk);
    end
    if (!end_done) begin
      $display("FAIL end_check_timeout: monitor did not complete final check");
      $fatal(1, "end check timeout");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Frame-level controller for the serial pattern-detection path. It accepts parallel frames over a valid/ready handshake and serialises them MSB-first, one bit per clock. Each bit is checked against a runtime-programmable bit pattern by a Mealy detector with overlap allowed. Per frame, the block counts matches and reports completion, so the generic detector can be configured and sequenced by a host.

## Interface
- `DATA_W`, default 16: frame width in bits, ≥ 2.
- `PAT_MAX`, default 8: maximum pattern length in bits, ≥ 2.
- `CNT_W`, default 8: width of the match counter.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cfg_we`, input, 1: pattern/length write strobe.
- `cfg_pat`, input, PAT_MAX: pattern. Bit `[len-1]` is the oldest (first-received) bit and bit `[0]` is the newest.
- `cfg_len`, input, $clog2(PAT_MAX+1): pattern length.
- `in_valid`, input, 1: frame offered.
- `in_ready`, output, 1: frame can be accepted.
- `in_data`, input, DATA_W: frame; `in_data[DATA_W-1]` is sent first.
- `bit_valid`, output, 1: `bit_out` carries a frame bit this cycle.
- `bit_out`, output, 1: current serial bit.
- `det`, output, 1: Mealy match pulse, asserted in the same cycle as the bit that completes the pattern.
- `busy`, output, 1: frame in progress (SHIFT or DONE).
- `done`, output, 1: one-cycle end-of-frame pulse.
- `match_cnt`, output, CNT_W: number of matches in the current or last frame.

## Operation
- **Reset values**:
  - State IDLE.
  - `bit_valid`, `bit_out`, `det`, `busy`, `done`, `match_cnt` all 0.
  - History cleared.
  - Active pattern = 3'b001 with length 3.
- **FSM IDLE**:
  - `in_ready = !cfg_we`.
  - If `cfg_we` is high: latch `cfg_pat`/`cfg_len` and clear the history. `cfg_we` has priority, so no frame is accepted that cycle.
  - Else if `in_valid`: load `in_data`, set bit index to 0, clear `match_cnt`, go to SHIFT.
- **FSM SHIFT**:
  - `in_ready` = 0, `bit_valid` = 1, `busy` = 1.
  - `bit_out = data[DATA_W-1-idx]`.
  - Increment idx. After the bit with idx = DATA_W-1, go to DONE.
- **FSM DONE**:
  - `done` = 1, `busy` = 1, `in_ready` = 0.
  - Next state is always IDLE.
- **cfg_we outside IDLE**: ignored. The active pattern never changes mid-frame.
- **Length clamp**: `cfg_len` = 0 is stored as 1; `cfg_len` > PAT_MAX is stored as PAT_MAX.
- **History**:
  - Shift register of the last PAT_MAX-1 serial bits, plus a fill count that saturates at PAT_MAX-1.
  - Persists across frames, so a match may span a frame boundary.
  - Cleared only by reset or by an accepted config write.
- **det** (combinational from state, history and current bit):
  - Requires state SHIFT and fill count ≥ len-1.
  - Requires `{hist[len-2:0], bit_out} == pat[len-1:0]`.
  - For len = 1: `det = (bit_out == pat[0])`.
- **Overlap**: matches may overlap; history is never flushed on a match.
- **match_cnt**:
  - Increments on each `det`, saturating at 2^CNT_W-1.
  - Cleared on frame accept; held from DONE until the next accept.

## Timing
- **Handshake**: a frame is accepted at the edge where `in_valid && in_ready`; call this edge k.
- **Serial bits**: appear in cycles k+1 … k+DATA_W. Bit i is in cycle k+1+i.
- **det**: for bit i, `det` is asserted in the same cycle k+1+i (zero latency, Mealy).
- **done**: in cycle k+DATA_W+1, with the final `match_cnt` valid in that cycle.
- **Next accept**: `in_ready` returns in cycle k+DATA_W+2. Minimum frame period is DATA_W+2 cycles.
- **Reset mid-frame**: abort at the next edge; all outputs return to reset values; no `done` is issued.
- **Simultaneous `cfg_we` and `in_valid` in IDLE**: the config write is taken and the frame waits; `in_valid` must be held.

## Test plan
- **Default pattern, DATA_W=16**:
  - Stimulus: after reset, send frame 16'h1249.
  - Required: `det` high in cycles k+4, k+7, k+10, k+13, k+16; `done` in k+17; `match_cnt` = 5.
- **Overlap**:
  - Stimulus: config pat=2'b11, len=2; send frame 16'hFFFF.
  - Required: 15 `det` pulses (none on the first bit, since history is empty); `match_cnt` = 15.
- **Cross-frame history**:
  - Stimulus: default pattern; send 16'h0000, then 16'h8000.
  - Required: first frame gives `match_cnt` = 0. Second frame gives `det` on its first bit and `match_cnt` = 1.
- **Config protection**:
  - Stimulus: pulse `cfg_we` (pat=1'b1, len=1) during SHIFT of frame 16'h1249.
  - Required: ignored; `match_cnt` = 5. The next frame still uses 001.
- **Saturation, CNT_W=2**:
  - Stimulus: pat=1'b1, len=1; send frame 16'hFFFF.
  - Required: 16 `det` pulses; `match_cnt` sticks at 3.
- **Reset mid-frame**:
  - Stimulus: assert `rst` at bit 5.
  - Required: next cycle `bit_valid`/`busy`/`det`/`match_cnt` = 0, `in_ready` = 1, no `done`; pattern reverts to 001.
